// File: rtl/pacman_game_sequencer.sv
// pacman_game_sequencer: frame-level game-flow controller for the Pacman top.
// It turns per-pixel coin/monster strobes into at most one event per frame and
// runs IDLE -> READY -> PLAY -> DYING / LEVEL_CLEAR -> GAME_OVER. It also keeps
// the score, lives, level and coins-left counters.
// Optional feature: define GAME_EXTRA_LIFE_EN to grant one extra life per game
// when the score first reaches EXTRA_LIFE_SCORE.
module pacman_game_sequencer #(
   parameter int COIN_COUNT       = 64,
   parameter int START_LIVES      = 3,
   parameter int MAX_LIVES        = 5,
   parameter int READY_FRAMES     = 90,
   parameter int DYING_FRAMES     = 60,
   parameter int CLEAR_FRAMES     = 120,
   parameter int COIN_POINTS      = 10,
   parameter int EXTRA_LIFE_SCORE = 1000
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        start_key,
   input  logic        coin_hit,
   input  logic        monster_hit,
   output logic [2:0]  game_state,
   output logic        play_enable,
   output logic        level_restart,
   output logic        pacman_restart,
   output logic [15:0] score,
   output logic [2:0]  lives,
   output logic [3:0]  level,
   output logic [7:0]  coins_left
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_DYING = 3'd3,
      S_CLEAR = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   localparam logic [7:0]  READY_LAST = 8'(READY_FRAMES - 1);
   localparam logic [7:0]  DYING_LAST = 8'(DYING_FRAMES - 1);
   localparam logic [7:0]  CLEAR_LAST = 8'(CLEAR_FRAMES - 1);
   localparam logic [7:0]  COINS_INIT = 8'(COIN_COUNT);
   localparam logic [2:0]  LIVES_INIT = 3'(START_LIVES);
   localparam logic [16:0] PTS        = 17'(COIN_POINTS);

   state_t      state_q, state_d;
   logic [7:0]  frame_q, frame_d;
   logic        coin_pend_q, coin_pend_d;
   logic        mon_pend_q, mon_pend_d;
   logic        key_q;
   logic [15:0] score_q, score_d;
   logic [2:0]  lives_q, lives_d;
   logic [3:0]  level_q, level_d;
   logic [7:0]  coins_q, coins_d;
   logic        play_q, play_d;
   logic        lvl_rst_q, lvl_rst_d;
   logic        pac_rst_q, pac_rst_d;

   logic        key_rise;
   logic [7:0]  frame_last;
   logic        timer_done;
   logic [7:0]  coins_dec;
   logic [16:0] score_sum;
   logic [15:0] score_sat;

`ifdef GAME_EXTRA_LIFE_EN
   localparam logic [16:0] XL_SCORE  = 17'(EXTRA_LIFE_SCORE);
   localparam logic [2:0]  LIVES_MAX = 3'(MAX_LIVES);
   logic        bonus_q, bonus_d;
`else
   logic [1:0]  unused_params;
   assign unused_params = {EXTRA_LIFE_SCORE[0], MAX_LIVES[0]};
`endif

   assign key_rise  = start_key & ~key_q;
   assign coins_dec = coins_q - 8'd1;
   assign score_sum = {1'b0, score_q} + PTS;
   assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

   // Pick the last frame index of whichever timed state is active
   always_comb begin
      frame_last = 8'hFF;
      case (state_q)
         S_READY:         frame_last = READY_LAST;
         S_DYING:         frame_last = DYING_LAST;
         S_CLEAR, S_OVER: frame_last = CLEAR_LAST;
         default:         frame_last = 8'hFF;
      endcase
   end

   assign timer_done = startOfFrame && (frame_q == frame_last);

   // Next-state, bookkeeping and restart-pulse decisions
   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      lives_d   = lives_q;
      level_d   = level_q;
      coins_d   = coins_q;
      lvl_rst_d = 1'b0;
      pac_rst_d = 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
      bonus_d   = bonus_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (key_rise) begin
               state_d   = S_READY;
               score_d   = 16'd0;
               lives_d   = LIVES_INIT;
               level_d   = 4'd1;
               coins_d   = COINS_INIT;
               lvl_rst_d = 1'b1;
               pac_rst_d = 1'b1;
`ifdef GAME_EXTRA_LIFE_EN
               bonus_d   = 1'b0;
`endif
            end
         end
         S_READY: begin
            if (timer_done) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (startOfFrame) begin
               if (coin_pend_q) begin
                  coins_d = coins_dec;
                  score_d = score_sat;
`ifdef GAME_EXTRA_LIFE_EN
                  if (!bonus_q && ({1'b0, score_q} < XL_SCORE) &&
                      ({1'b0, score_sat} >= XL_SCORE)) begin
                     bonus_d = 1'b1;
                     if (lives_q < LIVES_MAX) lives_d = lives_q + 3'd1;
                  end
`endif
               end
               // Clearing the level wins over a monster caught in the same frame
               if (coin_pend_q && (coins_dec == 8'd0)) state_d = S_CLEAR;
               else if (mon_pend_q)                    state_d = S_DYING;
            end
         end
         S_DYING: begin
            if (timer_done) begin
               lives_d = lives_q - 3'd1;
               if (lives_q == 3'd1) begin
                  state_d = S_OVER;
               end else begin
                  state_d   = S_READY;
                  pac_rst_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            if (timer_done) begin
               state_d   = S_READY;
               level_d   = (level_q == 4'd15) ? level_q : level_q + 4'd1;
               coins_d   = COINS_INIT;
               lvl_rst_d = 1'b1;
               pac_rst_d = 1'b1;
            end
         end
         S_OVER: begin
            if (timer_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Frame counter and per-frame event capture
   always_comb begin
      if (state_d != state_q) frame_d = 8'd0;
      else if (startOfFrame)  frame_d = frame_q + 8'd1;
      else                    frame_d = frame_q;

      coin_pend_d = coin_pend_q;
      mon_pend_d  = mon_pend_q;
      if (startOfFrame) begin
         coin_pend_d = 1'b0;
         mon_pend_d  = 1'b0;
      end else if (state_q == S_PLAY) begin
         coin_pend_d = coin_pend_q | coin_hit;
         mon_pend_d  = mon_pend_q | monster_hit;
      end
      play_d = (state_d == S_PLAY);
   end

   // State and counter registers; reset returns everything to a blank IDLE
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= S_IDLE;
         frame_q     <= 8'd0;
         coin_pend_q <= 1'b0;
         mon_pend_q  <= 1'b0;
         key_q       <= 1'b0;
         score_q     <= 16'd0;
         lives_q     <= 3'd0;
         level_q     <= 4'd0;
         coins_q     <= 8'd0;
         play_q      <= 1'b0;
         lvl_rst_q   <= 1'b0;
         pac_rst_q   <= 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
         bonus_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         coin_pend_q <= coin_pend_d;
         mon_pend_q  <= mon_pend_d;
         key_q       <= start_key;
         score_q     <= score_d;
         lives_q     <= lives_d;
         level_q     <= level_d;
         coins_q     <= coins_d;
         play_q      <= play_d;
         lvl_rst_q   <= lvl_rst_d;
         pac_rst_q   <= pac_rst_d;
`ifdef GAME_EXTRA_LIFE_EN
         bonus_q     <= bonus_d;
`endif
      end
   end

   assign game_state     = state_q;
   assign play_enable    = play_q;
   assign level_restart  = lvl_rst_q;
   assign pacman_restart = pac_rst_q;
   assign score          = score_q;
   assign lives          = lives_q;
   assign level          = level_q;
   assign coins_left     = coins_q;

endmodule
